// File: rtl/ps2_player_mover.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_player_mover
//  Purpose  : Turns PS/2 set-2 scan-code bytes (make / break, plain or E0
//             extended) into a held movement direction. Steps a player
//             (x, y) position by STEP pixels once per TICK_CYCLES-long tick.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clock      in   1        system clock
//    resetn     in   1        asynchronous active-low reset
//    key_data   in   8        scan-code byte from the PS/2 receiver
//    key_valid  in   1        single-cycle strobe, key_data valid
//    enable     in   1        movement enable (game running)
//    x          out  COORD_W  player x
//    y          out  COORD_W  player y
//    dir        out  3        0 still, 1 up, 2 left, 3 down, 4 right
//    tick       out  1        one-cycle pulse per tick period
//    moved      out  1        one-cycle pulse, aligned with x/y, on change
// ----------------------------------------------------------------------------
//  Configuration macro
//    PS2_PLAYER_MOVER_WRAP_EN  defined   : play-field edges wrap around
//                              undefined : play-field edges saturate
// ============================================================================
module ps2_player_mover #(
  parameter int TICK_CYCLES = 25000000,
  parameter int COORD_W     = 9,
  parameter int X_MAX       = 159,
  parameter int Y_MAX       = 119,
  parameter int X_INIT      = 0,
  parameter int Y_INIT      = 0,
  parameter int STEP        = 1
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic [7:0]         key_data,
  input  logic               key_valid,
  input  logic               enable,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic [2:0]         dir,
  output logic               tick,
  output logic               moved
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int CNT_W = $clog2(TICK_CYCLES);
  // One spare bit so that x+STEP and x-STEP never overflow / underflow
  // silently; the spare bit acts as the borrow of a subtraction.
  localparam int EXT_W = COORD_W + 1;

  localparam logic [CNT_W-1:0]   c_tick_last = CNT_W'(TICK_CYCLES - 1);
  localparam logic [CNT_W-1:0]   c_cnt_one   = CNT_W'(1);
  localparam logic [EXT_W-1:0]   c_step      = EXT_W'(STEP);
  localparam logic [EXT_W-1:0]   c_x_max     = EXT_W'(X_MAX);
  localparam logic [EXT_W-1:0]   c_y_max     = EXT_W'(Y_MAX);
  localparam logic [COORD_W-1:0] c_x_init    = COORD_W'(X_INIT);
  localparam logic [COORD_W-1:0] c_y_init    = COORD_W'(Y_INIT);
`ifdef PS2_PLAYER_MOVER_WRAP_EN
  localparam logic [EXT_W-1:0]   c_x_mod     = EXT_W'(X_MAX + 1);
  localparam logic [EXT_W-1:0]   c_y_mod     = EXT_W'(Y_MAX + 1);
`endif

  localparam logic [2:0] c_dir_still = 3'd0;
  localparam logic [2:0] c_dir_up    = 3'd1;
  localparam logic [2:0] c_dir_left  = 3'd2;
  localparam logic [2:0] c_dir_down  = 3'd3;
  localparam logic [2:0] c_dir_right = 3'd4;

  localparam logic [7:0] c_code_ext  = 8'hE0;
  localparam logic [7:0] c_code_brk  = 8'hF0;

  // --------------------------------------------------------------------------
  // Key map. Plain and extended code spaces are kept separate, so a code
  // only maps when it arrives with the matching prefix.
  // --------------------------------------------------------------------------
  function automatic logic [2:0] f_map(input logic [7:0] code, input logic ext);
    logic [2:0] d;
    d = c_dir_still;
    if (!ext) begin
      case (code)
        8'h1D:   d = c_dir_up;
        8'h1C:   d = c_dir_left;
        8'h1B:   d = c_dir_down;
        8'h23:   d = c_dir_right;
        default: d = c_dir_still;
      endcase
    end else begin
      case (code)
        8'h75:   d = c_dir_up;
        8'h6B:   d = c_dir_left;
        8'h72:   d = c_dir_down;
        8'h74:   d = c_dir_right;
        default: d = c_dir_still;
      endcase
    end
    return d;
  endfunction

  // --------------------------------------------------------------------------
  // Scan-code parser FSM: tracks the E0 / F0 prefixes of the packet in flight.
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXT    = 2'd1,
    ST_BRK    = 2'd2,
    ST_EXTBRK = 2'd3
  } parse_state_t;

  parse_state_t r_state;
  parse_state_t w_state_next;
  logic         w_code_done;  // key_data is the final byte of a packet
  logic         w_code_ext;   // packet carried the E0 prefix
  logic         w_code_brk;   // packet carried the F0 prefix (release)

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_code_done  = 1'b0;
    w_code_ext   = 1'b0;
    w_code_brk   = 1'b0;
    if (key_valid) begin
      case (r_state)
        ST_IDLE: begin
          if (key_data == c_code_ext) begin
            w_state_next = ST_EXT;
          end else if (key_data == c_code_brk) begin
            w_state_next = ST_BRK;
          end else begin
            w_code_done = 1'b1;
          end
        end
        ST_EXT: begin
          if (key_data == c_code_brk) begin
            w_state_next = ST_EXTBRK;
          end else begin
            w_state_next = ST_IDLE;
            w_code_done  = 1'b1;
            w_code_ext   = 1'b1;
          end
        end
        ST_BRK: begin
          w_state_next = ST_IDLE;
          w_code_done  = 1'b1;
          w_code_brk   = 1'b1;
        end
        ST_EXTBRK: begin
          w_state_next = ST_IDLE;
          w_code_done  = 1'b1;
          w_code_ext   = 1'b1;
          w_code_brk   = 1'b1;
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Held direction. A release only clears dir when it is the key currently
  // driving movement, so rolling from one key to another does not stall.
  // --------------------------------------------------------------------------
  logic [2:0] r_dir;
  logic [2:0] w_key_dir;
  logic [2:0] w_dir_next;

  assign w_key_dir = f_map(key_data, w_code_ext);

  always_comb begin
    w_dir_next = r_dir;
    if (w_code_done && (w_key_dir != c_dir_still)) begin
      if (!w_code_brk) begin
        w_dir_next = w_key_dir;
      end else if (w_key_dir == r_dir) begin
        w_dir_next = c_dir_still;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_dir <= c_dir_still;
    end else begin
      r_dir <= w_dir_next;
    end
  end

  // --------------------------------------------------------------------------
  // Tick counter. Held at zero while disabled so a re-enable always starts a
  // full period.
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] r_cnt;
  logic             w_tick;

  assign w_tick = enable && (r_cnt == c_tick_last);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_cnt <= '0;
    end else if (!enable || w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + c_cnt_one;
    end
  end

  // --------------------------------------------------------------------------
  // Movement datapath (one axis changes per tick).
  // --------------------------------------------------------------------------
  logic [COORD_W-1:0] r_x;
  logic [COORD_W-1:0] r_y;
  logic               r_moved;
  logic [EXT_W-1:0]   w_x_ext;
  logic [EXT_W-1:0]   w_y_ext;
  logic [EXT_W-1:0]   w_x_new;
  logic [EXT_W-1:0]   w_y_new;
  logic               w_go;
  logic               w_changed;

  assign w_x_ext = {1'b0, r_x};
  assign w_y_ext = {1'b0, r_y};

  always_comb begin
    w_x_new = w_x_ext;
    w_y_new = w_y_ext;
    case (r_dir)
      c_dir_up: begin
        if (w_y_ext < c_step) begin
`ifdef PS2_PLAYER_MOVER_WRAP_EN
          w_y_new = w_y_ext + c_y_mod - c_step;
`else
          w_y_new = '0;
`endif
        end else begin
          w_y_new = w_y_ext - c_step;
        end
      end
      c_dir_down: begin
        if (w_y_ext + c_step > c_y_max) begin
`ifdef PS2_PLAYER_MOVER_WRAP_EN
          w_y_new = w_y_ext + c_step - c_y_mod;
`else
          w_y_new = c_y_max;
`endif
        end else begin
          w_y_new = w_y_ext + c_step;
        end
      end
      c_dir_left: begin
        if (w_x_ext < c_step) begin
`ifdef PS2_PLAYER_MOVER_WRAP_EN
          w_x_new = w_x_ext + c_x_mod - c_step;
`else
          w_x_new = '0;
`endif
        end else begin
          w_x_new = w_x_ext - c_step;
        end
      end
      c_dir_right: begin
        if (w_x_ext + c_step > c_x_max) begin
`ifdef PS2_PLAYER_MOVER_WRAP_EN
          w_x_new = w_x_ext + c_step - c_x_mod;
`else
          w_x_new = c_x_max;
`endif
        end else begin
          w_x_new = w_x_ext + c_step;
        end
      end
      default: begin
        w_x_new = w_x_ext;
        w_y_new = w_y_ext;
      end
    endcase
  end

  // Movement uses the dir registered before this edge; a key arriving in
  // the same cycle as a tick only affects the following tick.
  assign w_go = w_tick && (r_dir != c_dir_still);

  // With wrapping, STEP < MAX+1 guarantees every step changes the coordinate,
  // so this comparison also yields a pulse on every moving tick there.
  assign w_changed = (w_x_new != w_x_ext) || (w_y_new != w_y_ext);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_x     <= c_x_init;
      r_y     <= c_y_init;
      r_moved <= 1'b0;
    end else begin
      r_moved <= w_go && w_changed;
      if (w_go) begin
        r_x <= w_x_new[COORD_W-1:0];
        r_y <= w_y_new[COORD_W-1:0];
      end
    end
  end

  assign x     = r_x;
  assign y     = r_y;
  assign dir   = r_dir;
  assign tick  = w_tick;
  assign moved = r_moved;

endmodule
`default_nettype wire
